// File: rtl/led_pwm_dimmer_pkg.sv
// Shared types and the brightness table formula for the LED PWM dimmer.
package led_pwm_dimmer_pkg;

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } duty_state_t;

  // duty_k = floor(k * 2^cnt_w / (levels-1)); evaluated with constant arguments only.
  function automatic int level_duty(input int k, input int cnt_w, input int levels);
    longint num;
    num = longint'(k) * (longint'(1) << cnt_w);
    return int'(num / longint'(levels - 1));
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled PWM tick generator and period counter, shareable between dimmer channels.
module pwm_timebase #(
  parameter int PRESCALE = 100,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             period_end
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] prescaler;

  assign tick       = (prescaler == PS_W'(PRESCALE - 1));
  assign period_end = tick && (cnt == {CNT_W{1'b1}});

  // Prescaler wraps on tick; the period counter advances on tick and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      cnt       <= '0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        cnt       <= cnt + CNT_W'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm_dimmer.sv
// Single-channel LED dimmer: button-driven level selection, level-to-duty table,
// optional duty fading at period boundaries and the PWM comparator.
module led_pwm_dimmer
  import led_pwm_dimmer_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int PRESCALE  = 100,
  parameter int LEVELS    = 5,
  parameter int FADE_STEP = 8,
  parameter int LVL_W     = $clog2(LEVELS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_off,
  input  logic             i_fade_en,
  output logic             o_pwm,
  output logic [LVL_W-1:0] o_level,
  output logic [CNT_W:0]   o_duty,
  output logic             o_busy
);

  localparam int DW = CNT_W + 1;
  localparam int EW = CNT_W + 2;
  // Any step >= full scale lands on the target in one period, so clamping keeps EW sums exact.
  localparam int STEP_LIM = (FADE_STEP > (1 << (CNT_W + 1))) ? (1 << (CNT_W + 1)) : FADE_STEP;
  localparam logic [LVL_W-1:0] MAX_LEVEL = LVL_W'(LEVELS - 1);
  localparam logic [EW-1:0]    STEP_EXT  = EW'(STEP_LIM);

  logic [CNT_W-1:0] cnt;
  logic             period_end;
  logic             unused_tick;
  logic [LVL_W-1:0] level_next;
  logic [DW-1:0]    target;
  logic [DW-1:0]    duty_next;
  logic [EW-1:0]    duty_ext;
  logic [EW-1:0]    target_ext;
  logic [EW-1:0]    sum_up;
  duty_state_t      state;
  duty_state_t      state_next;

  pwm_timebase #(
    .PRESCALE(PRESCALE),
    .CNT_W   (CNT_W)
  ) u_timebase (
    .clk       (i_clk),
    .rst       (i_reset),
    .cnt       (cnt),
    .tick      (unused_tick),
    .period_end(period_end)
  );

  // Level-to-duty lookup; levels beyond the table map to zero duty.
  always_comb begin
    target = '0;
    for (int k = 0; k < LEVELS; k++) begin
      if (o_level == LVL_W'(k)) begin
        target = DW'(level_duty(k, CNT_W, LEVELS));
      end else begin
        target = target;
      end
    end
  end

  // Button handling: off wins, simultaneous up/down cancels, both directions saturate.
  always_comb begin
    level_next = o_level;
    if (i_off) begin
      level_next = '0;
    end else if (i_up && !i_down) begin
      if (o_level != MAX_LEVEL) level_next = o_level + LVL_W'(1);
      else                      level_next = o_level;
    end else if (i_down && !i_up) begin
      if (o_level != '0) level_next = o_level - LVL_W'(1);
      else               level_next = o_level;
    end else begin
      level_next = o_level;
    end
  end

  assign duty_ext   = {1'b0, o_duty};
  assign target_ext = {1'b0, target};
  assign sum_up     = duty_ext + STEP_EXT;

  // Duty FSM: the applied duty only moves at period_end so no runt pulses appear.
  always_comb begin
    duty_next  = o_duty;
    state_next = state;
    if (period_end) begin
      if (!i_fade_en) begin
        duty_next  = target;
        state_next = STEADY;
      end else if (o_duty < target) begin
        duty_next  = (sum_up > target_ext) ? target : sum_up[DW-1:0];
        state_next = FADE_UP;
      end else if (o_duty > target) begin
        duty_next  = (duty_ext >= target_ext + STEP_EXT) ? DW'(duty_ext - STEP_EXT) : target;
        state_next = FADE_DOWN;
      end else begin
        state_next = STEADY;
      end
    end else begin
      duty_next  = o_duty;
      state_next = state;
    end
  end

  // Level, duty, FSM state and the registered PWM comparator.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_level <= '0;
      o_duty  <= '0;
      o_pwm   <= 1'b0;
      state   <= STEADY;
    end else begin
      o_level <= level_next;
      o_duty  <= duty_next;
      o_pwm   <= ({1'b0, cnt} < o_duty);
      state   <= state_next;
    end
  end

  assign o_busy = (o_duty != target);

endmodule
